// File: rtl/scr1_timer_arb_pkg.sv
// Shared types for the timer arbiter: SCR1 data-memory interface types,
// the arbiter FSM states, the master index and the default timeout.
package scr1_timer_arb_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH            = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH            = 32;
    localparam int unsigned SCR1_TIMER_ARB_TIMEOUT_DFLT = 16;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_TIMER_ARB_IDLE = 1'b0,
        SCR1_TIMER_ARB_BUSY = 1'b1
    } type_scr1_timer_arb_state_e;

    // Master index: 0 = core data port, 1 = system/debug bus
    typedef logic type_scr1_timer_arb_idx_t;

    // Request payload carried from a master to the timer
    typedef struct packed {
        type_scr1_mem_cmd_e            cmd;
        type_scr1_mem_width_e          width;
        logic [SCR1_DMEM_AWIDTH-1:0]   addr;
        logic [SCR1_DMEM_DWIDTH-1:0]   wdata;
    } type_scr1_timer_arb_req_s;

endpackage : scr1_timer_arb_pkg

// File: rtl/scr1_rr_arb2.sv
// Two-way round-robin pick: the lone requester, or prio on a tie.
module scr1_rr_arb2
    import scr1_timer_arb_pkg::*;
(
    input  logic [1:0]               req,
    input  type_scr1_timer_arb_idx_t prio,
    output type_scr1_timer_arb_idx_t sel,
    output logic                     valid
);

    // Select winner from the request vector
    always_comb begin
        valid = |req;
        sel   = 1'b0;
        case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = prio;
            default: sel = 1'b0;
        endcase
    end

endmodule : scr1_rr_arb2

// File: rtl/scr1_timer_arb.sv
// Two-master round-robin arbiter in front of the timer data-memory port.
// Optional BUSY-state response timeout: SCR1_TIMER_ARB_TIMEOUT_EN.
module scr1_timer_arb
    import scr1_timer_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = SCR1_TIMER_ARB_TIMEOUT_DFLT
) (
    input  logic                        clk,
    input  logic                        rst,
    // Master 0 (core data port)
    input  logic                        m0_req,
    input  type_scr1_mem_cmd_e          m0_cmd,
    input  type_scr1_mem_width_e        m0_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] m0_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] m0_wdata,
    output logic                        m0_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] m0_rdata,
    output type_scr1_mem_resp_e         m0_resp,
    // Master 1 (system/debug bus)
    input  logic                        m1_req,
    input  type_scr1_mem_cmd_e          m1_cmd,
    input  type_scr1_mem_width_e        m1_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] m1_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] m1_wdata,
    output logic                        m1_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] m1_rdata,
    output type_scr1_mem_resp_e         m1_resp,
    // Timer target
    output logic                        t_req,
    output type_scr1_mem_cmd_e          t_cmd,
    output type_scr1_mem_width_e        t_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] t_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] t_wdata,
    input  logic                        t_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0] t_rdata,
    input  type_scr1_mem_resp_e         t_resp
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 1024)) begin : g_bad_timeout
        $error("scr1_timer_arb: TIMEOUT_CYCLES must be in 2..1024");
    end

    type_scr1_timer_arb_state_e  r_state;
    type_scr1_timer_arb_state_e  w_state_next;
    type_scr1_timer_arb_idx_t    r_gnt;
    type_scr1_timer_arb_idx_t    r_prio;
    type_scr1_timer_arb_idx_t    w_sel;
    logic                        w_valid;
    logic                        w_accept;
    logic                        w_timeout;
    type_scr1_timer_arb_req_s    w_m0_pl;
    type_scr1_timer_arb_req_s    w_m1_pl;
    type_scr1_timer_arb_req_s    w_sel_pl;
    type_scr1_mem_resp_e         w_resp;
    logic [SCR1_DMEM_DWIDTH-1:0] w_rdata;

    assign w_m0_pl  = '{cmd: m0_cmd, width: m0_width, addr: m0_addr, wdata: m0_wdata};
    assign w_m1_pl  = '{cmd: m1_cmd, width: m1_width, addr: m1_addr, wdata: m1_wdata};
    assign w_sel_pl = w_sel ? w_m1_pl : w_m0_pl;
    assign w_accept = (r_state == SCR1_TIMER_ARB_IDLE) && w_valid && t_req_ack;

    scr1_rr_arb2 u_rr_arb2 (
        .req   ({m1_req, m0_req}),
        .prio  (r_prio),
        .sel   (w_sel),
        .valid (w_valid)
    );

`ifdef SCR1_TIMER_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_state == SCR1_TIMER_ARB_BUSY)
                    && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                    && (t_resp == SCR1_MEM_RESP_NOTRDY);

    // BUSY cycle counter, cleared on every accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == SCR1_TIMER_ARB_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCR1_TIMER_ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant and round-robin priority, updated on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt  <= 1'b0;
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_gnt  <= w_sel;
            r_prio <= ~w_sel;
        end
    end

    // Next state, request forwarding and response routing
    always_comb begin
        w_state_next = r_state;
        t_req        = 1'b0;
        t_cmd        = SCR1_MEM_CMD_RD;
        t_width      = SCR1_MEM_WIDTH_BYTE;
        t_addr       = '0;
        t_wdata      = '0;
        m0_req_ack   = 1'b0;
        m1_req_ack   = 1'b0;
        m0_resp      = SCR1_MEM_RESP_NOTRDY;
        m1_resp      = SCR1_MEM_RESP_NOTRDY;
        m0_rdata     = '0;
        m1_rdata     = '0;
        w_resp       = SCR1_MEM_RESP_NOTRDY;
        w_rdata      = '0;

        case (r_state)
            SCR1_TIMER_ARB_IDLE: begin
                if (w_valid) begin
                    t_req   = 1'b1;
                    t_cmd   = w_sel_pl.cmd;
                    t_width = w_sel_pl.width;
                    t_addr  = w_sel_pl.addr;
                    t_wdata = w_sel_pl.wdata;
                    if (w_sel) begin
                        m1_req_ack = t_req_ack;
                    end else begin
                        m0_req_ack = t_req_ack;
                    end
                    if (t_req_ack) begin
                        w_state_next = SCR1_TIMER_ARB_BUSY;
                    end
                end
            end
            SCR1_TIMER_ARB_BUSY: begin
                if (t_resp != SCR1_MEM_RESP_NOTRDY) begin
                    w_resp       = t_resp;
                    w_rdata      = t_rdata;
                    w_state_next = SCR1_TIMER_ARB_IDLE;
                end else if (w_timeout) begin
                    w_resp       = SCR1_MEM_RESP_RDY_ER;
                    w_state_next = SCR1_TIMER_ARB_IDLE;
                end
            end
        endcase

        if (r_gnt) begin
            m1_resp  = w_resp;
            m1_rdata = w_rdata;
        end else begin
            m0_resp  = w_resp;
            m0_rdata = w_rdata;
        end
    end

endmodule : scr1_timer_arb

// File: tb/tb_scr1_timer_arb.sv
// Scoreboard bench for scr1_timer_arb: stimulus pushes expected grants and
// responses from a transaction-level model; a negedge monitor pops/compares.
`timescale 1ns/1ps
module tb_scr1_timer_arb;
    import scr1_timer_arb_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        m0_req = 1'b0, m1_req = 1'b0;
    type_scr1_mem_cmd_e          m0_cmd = SCR1_MEM_CMD_RD, m1_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e        m0_width = SCR1_MEM_WIDTH_BYTE, m1_width = SCR1_MEM_WIDTH_BYTE;
    logic [31:0]                 m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic                        m0_req_ack, m1_req_ack;
    logic [31:0]                 m0_rdata, m1_rdata;
    type_scr1_mem_resp_e         m0_resp, m1_resp;
    logic                        t_req;
    type_scr1_mem_cmd_e          t_cmd;
    type_scr1_mem_width_e        t_width;
    logic [31:0]                 t_addr, t_wdata;
    logic                        t_req_ack = 1'b0;
    logic [31:0]                 t_rdata = '0;
    type_scr1_mem_resp_e         t_resp = SCR1_MEM_RESP_NOTRDY;

    scr1_timer_arb #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .t_req(t_req), .t_cmd(t_cmd), .t_width(t_width), .t_addr(t_addr), .t_wdata(t_wdata),
        .t_req_ack(t_req_ack), .t_rdata(t_rdata), .t_resp(t_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   m;
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e width;
        logic [31:0]          addr;
        logic [31:0]          wdata;
    } ack_t;

    typedef struct {
        int                  m;
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
    } rsp_t;

    ack_t ackq[$];
    rsp_t rspq[$];

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference: who is waiting, who owns the timer,
    // and who won the last grant (the other one wins the next tie)
    bit                   pend [2];
    type_scr1_mem_cmd_e   p_cmd [2];
    type_scr1_mem_width_e p_width [2];
    logic [31:0]          p_addr [2];
    logic [31:0]          p_wdata [2];
    bit                   mbusy = 1'b0;
    int                   mowner = 0;
    int                   mlast = 1;
    int                   mwait = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT presented an event the model did not predict", nm);
    endtask

    task automatic set_req(input int m, input type_scr1_mem_cmd_e c,
                           input type_scr1_mem_width_e w, input logic [31:0] a,
                           input logic [31:0] d);
        pend[m] = 1'b1; p_cmd[m] = c; p_width[m] = w; p_addr[m] = a; p_wdata[m] = d;
    endtask

    // One clock of stimulus plus the model's view of that clock
    task automatic step(input bit new0, input bit new1, input bit tack, input bit resp_en,
                        input type_scr1_mem_resp_e rv, input logic [31:0] rd);
        int w;
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            if (!pend[m] && ((m == 0) ? new0 : new1)) begin
                set_req(m, type_scr1_mem_cmd_e'($urandom_range(0, 1)),
                        type_scr1_mem_width_e'(2'($urandom_range(0, 2))),
                        $urandom, $urandom);
            end
        end
        m0_req = pend[0]; m0_cmd = p_cmd[0]; m0_width = p_width[0];
        m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
        m1_req = pend[1]; m1_cmd = p_cmd[1]; m1_width = p_width[1];
        m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
        t_req_ack = tack;
        t_resp    = resp_en ? rv : SCR1_MEM_RESP_NOTRDY;
        t_rdata   = rd;

        if (mbusy) begin
            if (resp_en && (rv != SCR1_MEM_RESP_NOTRDY)) begin
                rspq.push_back('{m: mowner, resp: rv, rdata: rd});
                mbusy = 1'b0;
            end
`ifdef SCR1_TIMER_ARB_TIMEOUT_EN
            else if (mwait == TB_TIMEOUT - 1) begin
                rspq.push_back('{m: mowner, resp: SCR1_MEM_RESP_RDY_ER, rdata: 32'h0});
                mbusy = 1'b0;
            end
`endif
            else begin
                mwait++;
            end
        end else if (pend[0] || pend[1]) begin
            w = (pend[0] && pend[1]) ? (1 - mlast) : (pend[1] ? 1 : 0);
            if (tack) begin
                ackq.push_back('{m: w, cmd: p_cmd[w], width: p_width[w],
                                 addr: p_addr[w], wdata: p_wdata[w]});
                mbusy  = 1'b1;
                mowner = w;
                mlast  = w;
                mwait  = 0;
                pend[w] = 1'b0;
            end
        end
    endtask

    task automatic mid_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; t_req_ack = 1'b0; t_resp = SCR1_MEM_RESP_NOTRDY;
        pend[0] = 1'b0; pend[1] = 1'b0;
        mbusy = 1'b0; mlast = 1; mwait = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: pop and compare whenever the DUT presents an ack or a response
    always @(negedge clk) begin
        ack_t a;
        rsp_t r;
        if (rst) begin
            chk("rst_t_req", 64'(t_req), 64'(0));
            chk("rst_t_payload", 64'({t_cmd, t_width, t_addr, t_wdata}), 64'(0));
            chk("rst_acks", 64'({m1_req_ack, m0_req_ack}), 64'(0));
            chk("rst_resp", 64'({m1_resp, m0_resp}), 64'(0));
            chk("rst_rdata", {m1_rdata, m0_rdata}, 64'(0));
        end else begin
            if (m0_req_ack || m1_req_ack) begin
                chk("ack_onehot", 64'(m0_req_ack && m1_req_ack), 64'(0));
                if (ackq.size() == 0) begin
                    unexpected("unexpected_ack");
                end else begin
                    a = ackq.pop_front();
                    chk("ack_master", 64'(m1_req_ack), 64'(a.m));
                    chk("ack_t_req", 64'(t_req), 64'(1));
                    chk("ack_t_cmd", 64'(t_cmd), 64'(a.cmd));
                    chk("ack_t_width", 64'(t_width), 64'(a.width));
                    chk("ack_t_addr", 64'(t_addr), 64'(a.addr));
                    chk("ack_t_wdata", 64'(t_wdata), 64'(a.wdata));
                end
            end
            if ((m0_resp != SCR1_MEM_RESP_NOTRDY) || (m1_resp != SCR1_MEM_RESP_NOTRDY)) begin
                if (rspq.size() == 0) begin
                    unexpected("unexpected_resp");
                end else begin
                    r = rspq.pop_front();
                    chk("resp_master", 64'(m1_resp != SCR1_MEM_RESP_NOTRDY), 64'(r.m));
                    chk("resp_code", 64'((r.m == 1) ? m1_resp : m0_resp), 64'(r.resp));
                    chk("resp_rdata", 64'((r.m == 1) ? m1_rdata : m0_rdata), 64'(r.rdata));
                    chk("resp_other_idle", 64'((r.m == 1) ? m0_resp : m1_resp),
                        64'(SCR1_MEM_RESP_NOTRDY));
                end
            end
            if (!t_req) chk("t_idle_payload", 64'({t_cmd, t_width, t_addr, t_wdata}), 64'(0));
            if (m0_resp == SCR1_MEM_RESP_NOTRDY) chk("m0_idle_rdata", 64'(m0_rdata), 64'(0));
            if (m1_resp == SCR1_MEM_RESP_NOTRDY) chk("m1_idle_rdata", 64'(m1_rdata), 64'(0));
        end
    end

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            p_cmd[m] = SCR1_MEM_CMD_RD; p_width[m] = SCR1_MEM_WIDTH_BYTE;
            p_addr[m] = '0; p_wdata[m] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single master read of 0x8, answered one cycle later
        set_req(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h8, 32'h0);
        step(0, 0, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'hdead_beef);
        step(0, 0, 0, 1, SCR1_MEM_RESP_RDY_OK, 32'h1234);

        // Tie: both request; m0 then m1, then m0 wins the next tie
        mid_reset();
        step(1, 1, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        step(0, 0, 1, 1, SCR1_MEM_RESP_RDY_OK, 32'h11);
        step(0, 0, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        step(1, 1, 1, 1, SCR1_MEM_RESP_RDY_OK, 32'h22);
        step(0, 0, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        step(0, 0, 1, 1, SCR1_MEM_RESP_RDY_OK, 32'h33);

        // Error passthrough on an m1 write, then an immediate new grant
        set_req(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h4, 32'hcafe);
        step(0, 0, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        step(0, 0, 1, 1, SCR1_MEM_RESP_RDY_ER, 32'h5555);
        step(1, 0, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        step(0, 0, 0, 1, SCR1_MEM_RESP_RDY_OK, 32'h77);

        // Fairness: m0 requests continuously, m1 once
        set_req(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'hc, 32'h0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 1, SCR1_MEM_RESP_RDY_OK, $urandom);

        // Reset one cycle after accept abandons the transaction
        step(1, 0, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        mid_reset();
        step(1, 1, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        step(0, 0, 0, 1, SCR1_MEM_RESP_RDY_OK, 32'h99);

`ifdef SCR1_TIMER_ARB_TIMEOUT_EN
        // Target never answers; stray late response in IDLE is ignored
        set_req(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
        step(0, 0, 1, 0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        for (int i = 0; i < TB_TIMEOUT; i++) step(0, 0, 0, 0, SCR1_MEM_RESP_NOTRDY, $urandom);
        step(0, 0, 0, 1, SCR1_MEM_RESP_RDY_OK, 32'habcd);
`endif

        // Randomized traffic, including stray responses while idle
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3),
                 ($urandom_range(0, 2) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK,
                 $urandom);
        end

        // Drain the outstanding transaction within a bounded budget
        for (int i = 0; i < 20; i++) begin
            if (!mbusy) break;
            step(0, 0, 0, 1, SCR1_MEM_RESP_RDY_OK, $urandom);
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0; t_req_ack = 1'b0; t_resp = SCR1_MEM_RESP_NOTRDY;
        @(negedge clk); #1;
        chk("ackq_drained", 64'(ackq.size()), 64'(0));
        chk("rspq_drained", 64'(rspq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_scr1_timer_arb

// File: doc/scr1_timer_arb.md
# scr1_timer_arb

Two-master arbiter in front of the memory-mapped timer's data-memory target port. It shares the timer between the core data port (master 0) and the system/debug bus (master 1). It grants one transaction at a time using round-robin priority and routes the timer's response back to the granted master only. It sits between the core/debug interconnect and the timer, and uses the same SCR1 memory-interface types.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: cycles in BUSY without a target response before a forced error. Used only with the timeout feature; legal range 2..1024.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- m0_req, m1_req  in  1  request from master 0 / master 1.
- m0_cmd, m1_cmd  in  type_scr1_mem_cmd_e  read or write.
- m0_width, m1_width  in  type_scr1_mem_width_e  access width.
- m0_addr, m1_addr  in  SCR1_DMEM_AWIDTH  address.
- m0_wdata, m1_wdata  in  SCR1_DMEM_DWIDTH  write data.
- m0_req_ack, m1_req_ack  out  1  request accepted.
- m0_rdata, m1_rdata  out  SCR1_DMEM_DWIDTH  read data.
- m0_resp, m1_resp  out  type_scr1_mem_resp_e  response.
- t_req, t_cmd, t_width, t_addr, t_wdata  out  (as above)  request to the timer.
- t_req_ack  in  1  timer accept.
- t_rdata  in  SCR1_DMEM_DWIDTH  timer read data.
- t_resp  in  type_scr1_mem_resp_e  timer response.

## Operation
- States: IDLE, BUSY. A registered `gnt` (master index) and `prio` (index with priority on the next tie) record the grant.
- IDLE:
  - Select a master: the only requester, or `prio` if both request.
  - Forward the selected request to t_* combinationally. The selected master's req_ack equals t_req_ack; the other master's req_ack is 0.
  - On t_req & t_req_ack: latch gnt, set prio to the other master, go to BUSY.
- BUSY:
  - t_req=0; both req_ack=0.
  - On t_resp != SCR1_MEM_RESP_NOTRDY: drive t_resp and t_rdata to m[gnt]_resp/rdata in the same cycle, then return to IDLE.
- A master that is not granted sees resp=SCR1_MEM_RESP_NOTRDY and rdata=0.
- A master must hold req and its payload stable until req_ack. The arbiter never drops a held request, and no master is starved: a losing master wins the next tie.
- t_cmd/width/addr/wdata are zero when t_req=0.
- A target response that arrives in IDLE is ignored; no master receives it.

## Timing
- Reset: state=IDLE, prio=0, gnt=0.
- All outputs reset to combinational idle values: req_ack=0, resp=NOTRDY, rdata=0, t_req=0, and t_cmd/width/addr/wdata=0.
- Request path is zero-latency: a request is accepted in the same cycle it is presented if t_req_ack=1.
- The timer answers one cycle after accept. Each transaction therefore takes 2 cycles, and maximum throughput is one transaction per 2 cycles.
- No new grant is issued in the cycle a response is forwarded. The next grant happens in the following IDLE cycle.
- When rst asserts mid-transaction, the arbiter returns to IDLE immediately and the outstanding transaction is abandoned.

## Configuration
- SCR1_TIMER_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES-1 with t_resp=NOTRDY, the arbiter drives m[gnt]_resp=SCR1_MEM_RESP_RDY_ER with rdata=0 for one cycle, then returns to IDLE.
  - If a real response arrives in that same cycle, the real response wins.
- SCR1_TIMER_ARB_TIMEOUT_EN undefined:
  - No counter is built and TIMEOUT_CYCLES is unused.
  - BUSY waits for a target response indefinitely.

## Structure
- Shared package/header (alongside the memif types) holds:
  - type_scr1_timer_arb_state_e {IDLE, BUSY};
  - the one-bit master-index typedef;
  - the default timeout constant.
- One sub-module, scr1_rr_arb2: purely combinational two-way round-robin pick. Inputs: req[1:0], prio. Outputs: sel, valid. The top holds the FSM, the registers, and the muxing.

## Test plan
- Single master: m0 reads addr 0x8 with t_req_ack=1 and t_rdata=0x1234 one cycle later -> m0_req_ack=1 in cycle 0; m0_resp=RDY_OK and m0_rdata=0x1234 in cycle 1; m1 outputs stay NOTRDY/0.
- Tie after reset: m0 and m1 both request in cycle 0 -> m0 granted first, m1 acked in cycle 2, and m0 wins the next tie.
- Fairness: m0 requests continuously and m1 requests once -> m1 is granted no later than the second grant opportunity.
- Error passthrough: m1 writes with t_resp=RDY_ER -> m1_resp=RDY_ER for exactly one cycle, then the arbiter returns to IDLE.
- Reset mid-BUSY: assert rst one cycle after accept -> all outputs go to their idle values; the next request is granted to m0.
- Timeout (macro defined, TIMEOUT_CYCLES=4): target never responds -> granted master gets RDY_ER with rdata=0 after 4 BUSY cycles; a late t_resp arriving in IDLE is ignored.
